// File: rtl/sprite_icon_engine_pkg.sv
// Shared types and constants for the tank/burst sprite renderer.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_E = 2'b01,
    DIR_S = 2'b10,
    DIR_W = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    BURST   = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  localparam logic [11:0] PAL_WHITE           = 12'hFFF;
  localparam logic [11:0] PAL_BLACK           = 12'h000;
  localparam logic [11:0] PAL_RED_DEFAULT     = 12'hA13;
  localparam logic [11:0] PAL_BLUE            = 12'h025;
  localparam logic [11:0] TRANSPARENT_DEFAULT = 12'hFFF;

  // Tank ROM stores 2-bit palette indices; entry 2 is the per-team colour.
  function automatic logic [11:0] palette(input logic [1:0] idx, input logic [11:0] red);
    logic [11:0] col;
    case (idx)
      2'd0:    col = PAL_WHITE;
      2'd1:    col = PAL_BLACK;
      2'd2:    col = red;
      default: col = PAL_BLUE;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/sprite_icon_engine_if.sv
// Sprite ROM bus: one shared address, per-ROM enables, 1-clock read data.
interface sprite_icon_engine_if #(
  parameter int ICON_LOG2 = 5,
  parameter int COLOR_W   = 12
);
  logic [2*ICON_LOG2-1:0] rom_addr;
  logic                   rom_tank_en;
  logic                   rom_burst_en;
  logic [1:0]             rom_tank_data;
  logic [COLOR_W-1:0]     rom_burst_data;

  modport master (
    output rom_addr, rom_tank_en, rom_burst_en,
    input  rom_tank_data, rom_burst_data
  );

  modport slave (
    input  rom_addr, rom_tank_en, rom_burst_en,
    output rom_tank_data, rom_burst_data
  );
endinterface

// File: rtl/sprite_icon_engine_addr_rotator.sv
// Combinational sprite ROM address rotation by cardinal direction.
module sprite_addr_rotator
  import sprite_pkg::*;
#(
  parameter int ICON_LOG2 = 5
) (
  input  logic [ICON_LOG2-1:0]   r_i,
  input  logic [ICON_LOG2-1:0]   c_i,
  input  logic [1:0]             dir_i,
  output logic [2*ICON_LOG2-1:0] addr_o
);

  always_comb begin
    addr_o = {r_i, c_i};
    case (dir_t'(dir_i))
      DIR_N:   addr_o = {r_i, c_i};
      DIR_E:   addr_o = {~c_i, r_i};
      DIR_S:   addr_o = {~r_i, ~c_i};
      DIR_W:   addr_o = {c_i, ~r_i};
      default: addr_o = {r_i, c_i};
    endcase
  end

endmodule

// File: rtl/sprite_icon_engine.sv
// Tank/burst sprite renderer with hit -> burst -> respawn sequencing.
// Optional flashing explosion when SPRITE_BLINK_EN is defined.
module sprite_icon_engine
  import sprite_pkg::*;
#(
  parameter int               ICON_LOG2     = 5,
  parameter int               COLOR_W       = 12,
  parameter int               X_SHIFT       = 3,
  parameter int               Y_MULT        = 6,
  parameter int unsigned      BURST_CYCLES  = 32'h3000000,
  parameter int unsigned      RESPAWN_PULSE = 16,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(TRANSPARENT_DEFAULT),
  parameter logic [COLOR_W-1:0] TANK_RED    = COLOR_W'(PAL_RED_DEFAULT)
`ifdef SPRITE_BLINK_EN
  , parameter int             BLINK_BIT     = 22
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          pixel_column,
  input  logic [11:0]          pixel_row,
  input  logic [7:0]           loc_x,
  input  logic [7:0]           loc_y,
  input  logic [2:0]           orient,
  input  logic                 hit,
  sprite_icon_engine_if.master rom,
  output logic                 icon,
  output logic [COLOR_W-1:0]   icon_c,
  output logic                 burst,
  output logic                 respawn,
  output state_t               dbg_state
);

  // Fixed-latency stream, no valid/ready: a pixel is taken every clock and
  // its icon/icon_c appear exactly 3 clocks later; nothing back-pressures.
  localparam logic [31:0] BURST_LAST   = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] RESPAWN_LAST = 32'(RESPAWN_PULSE - 1);

  state_t                 state_q;
  logic [31:0]            cnt_q;
  logic                   burst_q, respawn_q;
  logic [11:0]            col_base, row_base;
  logic [12:0]            col_end, row_end;
  logic [ICON_LOG2-1:0]   r_off, c_off;
  logic                   inside_d, inside_d1_q, inside_d2_q, burst_d2_q;
  logic [2*ICON_LOG2-1:0] rom_addr_d, rom_addr_q;
  logic [COLOR_W-1:0]     sel_color, icon_c_q;
  logic                   icon_d, icon_q;
  logic                   unused_orient;

  assign unused_orient = orient[0];

  // Upper bounds are 13 bits wide so an edge sprite never wraps to 0.
  assign col_base = 12'({loc_x, {X_SHIFT{1'b0}}});
  assign row_base = 12'(loc_y * Y_MULT);
  assign col_end  = {1'b0, col_base} + 13'(1 << ICON_LOG2);
  assign row_end  = {1'b0, row_base} + 13'(1 << ICON_LOG2);
  assign inside_d = (pixel_column >= col_base) && ({1'b0, pixel_column} < col_end) &&
                    (pixel_row >= row_base) && ({1'b0, pixel_row} < row_end);
  assign r_off    = ICON_LOG2'(pixel_row - row_base);
  assign c_off    = ICON_LOG2'(pixel_column - col_base);

  sprite_addr_rotator #(.ICON_LOG2(ICON_LOG2)) u_rot (
    .r_i    (r_off),
    .c_i    (c_off),
    .dir_i  (orient[2:1]),
    .addr_o (rom_addr_d)
  );

  // burst_d2_q mirrors the ROM enable that was active when S2 data was read.
  assign sel_color = burst_d2_q ? rom.rom_burst_data
                                : COLOR_W'(palette(rom.rom_tank_data, 12'(TANK_RED)));

  always_comb begin
    icon_d = inside_d2_q && (sel_color != TRANSPARENT);
`ifdef SPRITE_BLINK_EN
    if (state_q == BURST && cnt_q[BLINK_BIT]) icon_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rom_addr_q  <= '0;
      inside_d1_q <= 1'b0;
      inside_d2_q <= 1'b0;
      burst_d2_q  <= 1'b0;
      icon_q      <= 1'b0;
      icon_c_q    <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      inside_d1_q <= inside_d;
      inside_d2_q <= inside_d1_q;
      burst_d2_q  <= burst_q;
      icon_q      <= icon_d;
      if (inside_d2_q) icon_c_q <= sel_color;
    end
  end

  // A hit in BURST restarts the count and takes priority over terminal count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ALIVE;
      cnt_q     <= '0;
      burst_q   <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit) begin
            state_q <= BURST;
            cnt_q   <= '0;
            burst_q <= 1'b1;
          end
        end
        BURST: begin
          if (hit) begin
            cnt_q <= '0;
          end else if (cnt_q == BURST_LAST) begin
            state_q   <= RESPAWN;
            cnt_q     <= '0;
            burst_q   <= 1'b0;
            respawn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        RESPAWN: begin
          if (cnt_q == RESPAWN_LAST) begin
            state_q   <= ALIVE;
            cnt_q     <= '0;
            respawn_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q   <= ALIVE;
          cnt_q     <= '0;
          burst_q   <= 1'b0;
          respawn_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom.rom_addr     = rom_addr_q;
  assign rom.rom_burst_en = burst_q;
  assign rom.rom_tank_en  = ~burst_q;
  assign icon             = icon_q;
  assign icon_c           = icon_c_q;
  assign burst            = burst_q;
  assign respawn          = respawn_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sprite_icon_engine.sv
// Randomized scoreboard bench for sprite_icon_engine (short burst/respawn timing).
module tb_sprite_icon_engine;
  import sprite_pkg::*;

  localparam int BC = 20;
  localparam int RP = 4;
  localparam int EW = 48;
  localparam int HN = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pixel_column = '0, pixel_row = '0;
  logic [7:0]  loc_x = '0, loc_y = '0;
  logic [2:0]  orient = '0;
  logic        hit = 1'b0;
  logic        icon, burst, respawn;
  logic [11:0] icon_c;
  state_t      dbg_state;

  sprite_icon_engine_if #(.ICON_LOG2(5), .COLOR_W(12)) rom_bus ();

  sprite_icon_engine #(
    .ICON_LOG2(5), .COLOR_W(12), .BURST_CYCLES(BC), .RESPAWN_PULSE(RP)
`ifdef SPRITE_BLINK_EN
    , .BLINK_BIT(2)
`endif
  ) dut (
    .clock(clock), .reset(reset), .pixel_column(pixel_column), .pixel_row(pixel_row),
    .loc_x(loc_x), .loc_y(loc_y), .orient(orient), .hit(hit), .rom(rom_bus),
    .icon(icon), .icon_c(icon_c), .burst(burst), .respawn(respawn), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ROMs ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [1:0]  tank_rom  [1024];
  logic [11:0] burst_rom [1024];
  always @(posedge clock) begin
    if (rom_bus.rom_tank_en)  rom_bus.rom_tank_data  <= tank_rom[rom_bus.rom_addr];
    if (rom_bus.rom_burst_en) rom_bus.rom_burst_data <= burst_rom[rom_bus.rom_addr];
  end

  // ---------------- reference model ----------------
  int          tests = 0, fails = 0;
  int          last_hit = -1000;
  int          hist [HN];
  logic [11:0] last_c = '0;
  logic [EW-1:0] ctrl_q[$], addr_q[$], icon_q[$];

  function automatic logic [11:0] pal(input logic [1:0] i);
    case (i)
      2'd0:    return 12'hFFF;
      2'd1:    return 12'h000;
      2'd2:    return 12'hA13;
      default: return 12'h025;
    endcase
  endfunction

  // Burst lasts BC clocks from the accepting edge, then RP clocks of respawn.
  function automatic bit is_burst(input int n);
    int d = n - hist[n];
    return d >= 0 && d < BC;
  endfunction

  function automatic bit is_resp(input int n);
    int d = n - hist[n];
    return d >= BC && d < BC + RP;
  endfunction

  task automatic pix_model(input int px, input int py, input int lx, input int ly,
                           input logic [2:0] o, output bit ins, output logic [9:0] addr);
    int col, row, r, c, a, b;
    col = (lx * 8) % 4096;
    row = (ly * 6) % 4096;
    ins = px >= col && px < col + 32 && py >= row && py < row + 32;
    r = (py - row) & 31;
    c = (px - col) & 31;
    case (o[2:1])
      2'd0:    begin a = r;      b = c;      end
      2'd1:    begin a = 31 - c; b = r;      end
      2'd2:    begin a = 31 - r; b = 31 - c; end
      default: begin a = c;      b = 31 - r; end
    endcase
    addr = 10'(a * 32 + b);
  endtask

  // ---------------- driver ----------------
  task automatic step(input int px, input int py, input int lx, input int ly,
                      input logic [2:0] o, input logic h, input logic rst_n, input bit chk);
    int k, e;
    bit ins, bs;
    logic [9:0] a;
    logic [11:0] color;
    @(posedge clock);
    #1;
    k = cyc;
    e = k + 1;
    pixel_column = 12'(px); pixel_row = 12'(py);
    loc_x = 8'(lx); loc_y = 8'(ly); orient = o; hit = h; reset = rst_n;
    if (!rst_n) begin
      last_hit = -1000;
      last_c   = '0;
    end else if (h && !is_resp(k)) begin
      last_hit = e;
    end
    hist[e] = last_hit;
    bs = is_burst(e);
    ctrl_q.push_back({32'(e), 12'd0, bs, is_resp(e), !bs, bs});
    pix_model(px, py, lx, ly, o, ins, a);
    color = bs ? burst_rom[a] : pal(tank_rom[a]);
    if (rst_n && chk) begin
      addr_q.push_back({32'(e), 6'd0, a});
      icon_q.push_back({32'(k + 3), 3'd0, ins && (color != 12'hFFF), ins ? color : last_c});
    end
    if (rst_n && ins) last_c = color;
  endtask

  task automatic in_step(input logic h);
    step(80 + $urandom_range(0, 31), 60 + $urandom_range(0, 31), 10, 10,
         3'($urandom_range(0, 7)), h, 1'b1, 1'b1);
  endtask

  task automatic out_step(input logic h, input logic rst_n);
    step(0, 0, 10, 10, 3'd0, h, rst_n, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] me;
  logic [15:0]   mexp, mact;
  int            mcyc, md;

  always @(negedge clock) begin
    while (ctrl_q.size() > 0 && int'(ctrl_q[0][47:16]) <= cyc) begin
      me = ctrl_q.pop_front(); mcyc = int'(me[47:16]);
      mexp = me[15:0];
      mact = {12'd0, burst, respawn, rom_bus.rom_tank_en, rom_bus.rom_burst_en};
      tests++;
      if (mcyc != cyc || mact != mexp) begin
        fails++;
        $display("FAIL ctrl cyc=%0d due=%0d got %h want %h", cyc, mcyc, mact, mexp);
      end
    end
    while (addr_q.size() > 0 && int'(addr_q[0][47:16]) <= cyc) begin
      me = addr_q.pop_front(); mcyc = int'(me[47:16]);
      mexp = me[15:0];
      mact = {6'd0, rom_bus.rom_addr};
      tests++;
      if (mcyc != cyc || mact != mexp) begin
        fails++;
        $display("FAIL rom_addr cyc=%0d due=%0d got %h want %h", cyc, mcyc, mact, mexp);
      end
    end
    while (icon_q.size() > 0 && int'(icon_q[0][47:16]) <= cyc) begin
      me = icon_q.pop_front(); mcyc = int'(me[47:16]);
      mexp = me[15:0];
`ifdef SPRITE_BLINK_EN
      md = (cyc - 1) - hist[cyc - 1];
      if (md >= 0 && md < BC && md[2]) mexp[12] = 1'b0;
`endif
      mact = {3'd0, icon, icon_c};
      tests++;
      if (mcyc != cyc || mact != mexp) begin
        fails++;
        $display("FAIL icon cyc=%0d due=%0d got %h want %h", cyc, mcyc, mact, mexp);
      end
    end
  end

  task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lx, ly, px, py;
    for (int i = 0; i < HN; i++) hist[i] = -1000;
    for (int i = 0; i < 1024; i++) begin
      tank_rom[i]  = 2'($urandom_range(0, 3));
      burst_rom[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4094));
    end
    tank_rom[0] = 2'd0;
    tank_rom[1] = 2'd2;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_now("reset_icon", {15'd0, icon}, 16'd0);
    check_now("reset_icon_c", {4'd0, icon_c}, 16'd0);
    check_now("reset_burst", {15'd0, burst}, 16'd0);
    check_now("reset_respawn", {15'd0, respawn}, 16'd0);
    check_now("reset_rom_addr", {6'd0, rom_bus.rom_addr}, 16'd0);
    check_now("reset_state", {14'd0, dbg_state}, {14'd0, ALIVE});

    // Directed window, rotation and edge cases.
    step(80, 60, 10, 10, 3'd0, 1'b0, 1'b1, 1'b1);
    step(111, 91, 10, 10, 3'd0, 1'b0, 1'b1, 1'b1);
    step(81, 60, 10, 10, 3'd2, 1'b0, 1'b1, 1'b1);
    step(81, 60, 10, 10, 3'd4, 1'b0, 1'b1, 1'b1);
    step(81, 60, 10, 10, 3'd6, 1'b0, 1'b1, 1'b1);
    step(81, 60, 10, 10, 3'd3, 1'b0, 1'b1, 1'b1);
    step(81, 60, 10, 10, 3'd0, 1'b0, 1'b1, 1'b1);
    step(112, 60, 10, 10, 3'd0, 1'b0, 1'b1, 1'b1);
    step(0, 60, 127, 10, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1047, 60, 127, 10, 3'd1, 1'b0, 1'b1, 1'b1);
    step(1048, 60, 127, 10, 3'd5, 1'b0, 1'b1, 1'b1);

    // Random pixels around random sprite positions.
    for (int i = 0; i < 150; i++) begin
      lx = $urandom_range(0, 255);
      ly = $urandom_range(0, 255);
      px = lx * 8 + $urandom_range(0, 40) - 4;
      py = ly * 6 + $urandom_range(0, 40) - 4;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      step(px, py, lx, ly, 3'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b1);
    end

    // Single hit: full burst then respawn, burst ROM feeding icon_c.
    in_step(1'b1);
    repeat (30) in_step(1'b0);

    // Hit at terminal count extends; hit during respawn is ignored.
    in_step(1'b1);
    repeat (19) in_step(1'b0);
    in_step(1'b1);
    repeat (20) in_step(1'b0);
    in_step(1'b1);
    repeat (8) in_step(1'b0);

    // Reset mid-burst.
    repeat (3) out_step(1'b0, 1'b1);
    out_step(1'b1, 1'b1);
    repeat (10) out_step(1'b0, 1'b1);
    out_step(1'b0, 1'b0);
    repeat (4) out_step(1'b0, 1'b1);
    repeat (10) in_step(1'b0);

    // Random hits with live pixels.
    for (int i = 0; i < 120; i++) in_step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    repeat (30) in_step(1'b0);
    repeat (3) out_step(1'b0, 1'b1);

    repeat (4) @(posedge clock);
    @(negedge clock);
    tests++;
    if (ctrl_q.size() + addr_q.size() + icon_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", ctrl_q.size() + addr_q.size() + icon_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_icon_engine.md
Name: sprite_icon_engine

Overview:
Parametrised tank/burst sprite renderer for the World of Tank display path. Maps a 128x128 rojobot map position onto the 1024x768 pixel grid and rotates a square sprite by bot orientation. Fetches the tank or burst sprite from external synchronous ROMs and emits a registered opaque flag and colour to the colorizer. Owns the hit -> burst -> respawn sequence, which replaces the per-tank ad-hoc counters.

Parameters:
ICON_LOG2, 5, sprite edge = 2^ICON_LOG2 pixels (32)
COLOR_W, 12, RGB colour width
X_SHIFT, 3, map X to pixel column: col = loc_x << X_SHIFT
Y_MULT, 6, map Y to pixel row: row = loc_y * Y_MULT
BURST_CYCLES, 32'h3000000, clocks the burst sprite is shown
RESPAWN_PULSE, 16, width of the respawn pulse in clocks
TRANSPARENT, 12'hFFF, colour treated as see-through
TANK_RED, 12'hA13, palette entry 2 (entry 3 = 12'h025)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
pixel_column  in  12  current column from dtg
pixel_row  in  12  current row from dtg
loc_x  in  8  bot X (map units)
loc_y  in  8  bot Y (map units)
orient  in  3  BotInfo[2:0] orientation
hit  in  1  one-or-more-cycle hit indication
rom_addr  out  2*ICON_LOG2  shared sprite ROM address
rom_tank_en  out  1  tank ROM enable
rom_burst_en  out  1  burst ROM enable
rom_tank_data  in  2  tank ROM douta, 1-clock read latency
rom_burst_data  in  COLOR_W  burst ROM douta, 1-clock read latency
icon  out  1  1 = sprite pixel opaque
icon_c  out  COLOR_W  sprite pixel colour
burst  out  1  high while in BURST
respawn  out  1  respawn pulse to the bot's reset

Behaviour:
- Clock and reset: reset reset, synchronous, active-low; clock clock.
- Reset values: icon=0, icon_c=0, burst=0, respawn=0, rom_addr=0, FSM=ALIVE, counter=0.
- Window:
  - col = {loc_x,X_SHIFT'b0} and row = loc_y*Y_MULT, both truncated to 12 bits.
  - Inside when col <= pixel_column < col+2^ICON_LOG2 and row <= pixel_row < row+2^ICON_LOG2.
  - The upper bounds are computed 13-bit, so a sprite at the right or bottom edge never wraps to column or row 0.
- Offsets: r = pixel_row-row, c = pixel_column-col, each ICON_LOG2 bits. ~ denotes 2^ICON_LOG2-1 minus the offset.
- Rotation by orient[2:1]; orient[0]=1 (diagonal) renders as the preceding cardinal:
  - 00 N: {r,c}
  - 01 E: {~c,r}
  - 10 S: {~r,~c}
  - 11 W: {c,~r}
- Pipeline, fixed 3-clock latency from pixel inputs to icon/icon_c:
  - S1 registers rom_addr and inside_d1.
  - S2: ROM data valid; inside_d2 and the burst select are delayed to match.
  - S3 registers icon_c = burst_d2 ? rom_burst_data : palette(rom_tank_data) (0 white, 1 black, 2 TANK_RED, 3 12'h025).
  - S3 also registers icon = inside_d2 & (selected colour != TRANSPARENT).
  - Opacity is evaluated on the current colour, not on the previous icon_c.
  - Outside the window: icon=0 and icon_c holds.
- ROM enables: rom_burst_en = burst, rom_tank_en = ~burst.
- FSM:
  - ALIVE: hit -> BURST, counter=0.
  - BURST:
    - hit restarts the counter at 0 (burst is extended).
    - Otherwise the counter increments.
    - counter == BURST_CYCLES-1 -> RESPAWN, counter=0.
    - hit and terminal count in the same cycle: hit wins, stay in BURST.
  - RESPAWN:
    - respawn=1; hit is ignored.
    - counter == RESPAWN_PULSE-1 -> ALIVE with respawn=0, counter=0.
    - respawn is high for exactly RESPAWN_PULSE clocks.
  - burst = (state==BURST), registered.
- Reset mid-burst or mid-respawn returns to ALIVE in the next clock with all outputs 0.

Optional Feature:
SPRITE_BLINK_EN
- Defined: during BURST, icon is forced 0 whenever counter[BLINK_BIT] is 1, giving a flashing explosion. BLINK_BIT is a parameter, default 22.
- Undefined: the burst sprite is shown steadily; no BLINK_BIT logic is generated.

Decomposition:
- Package sprite_pkg holds:
  - orientation encodings (N=2'b00, E, S, W)
  - FSM state enum {ALIVE, BURST, RESPAWN}
  - palette constants
  - TRANSPARENT default
- One natural sub-module: sprite_addr_rotator, which takes r, c and orient[2:1] and returns the rotated ROM address; it is combinational and instantiated before the S1 register.

Test Plan:
Bench runs with BURST_CYCLES=20, RESPAWN_PULSE=4; ROM models return known patterns.
- loc_x=10, loc_y=10, orient=0; pixel (80,60) -> rom_addr=0 at S1; (111,91) -> rom_addr=0x3FF; icon valid exactly 3 clocks after each pixel.
- orient=2 (E), pixel (81,60) -> rom_addr={5'd30,5'd0}; orient=4 (S) -> {31,30}; orient=6 (W) -> {1,31}; orient=3 -> same as 2.
- Tank ROM returns 0 -> icon=0; returns 2 -> icon=1, icon_c=12'hA13; pixel (112,60) -> icon=0; loc_x=127 with pixel_column=0 -> icon=0 (no wrap).
- 1-cycle hit -> burst=1 next clock for 20 clocks, then respawn=1 for exactly 4 clocks, then ALIVE; icon_c is sourced from the burst ROM while burst=1.
- hit at burst count 19 -> burst stays 1 for another 20 clocks; hit during RESPAWN -> no effect; reset low at burst count 10 -> burst=0, respawn=0 next clock.
- With SPRITE_BLINK_EN defined and BLINK_BIT=2: icon alternates 4 clocks on / 4 clocks off during BURST over an opaque burst pixel.
